// File: rtl/tim_cmp_pkg.sv
// tim_cmp_pkg: shared constants for the multi-channel compare bank.
// Holds global register addresses, channel slot layout, per-channel register
// offsets, CTRL bit positions and the maximum channel count.
package tim_cmp_pkg;

  localparam int MAX_CH = 8;

  localparam logic [11:0] ISR_ADDR  = 12'h080;
  localparam logic [11:0] OVR_ADDR  = 12'h084;
  localparam logic [11:0] CH_BASE   = 12'h100;
  localparam logic [11:0] CH_STRIDE = 12'h010;

  localparam logic [3:0] CMPL_OFF   = 4'h0;
  localparam logic [3:0] CMPH_OFF   = 4'h4;
  localparam logic [3:0] CTRL_OFF   = 4'h8;
  localparam logic [3:0] PERIOD_OFF = 4'hC;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_INT_EN   = 2;

  // Word select inside a channel slot (byte offset [3:2]).
  typedef enum logic [1:0] {
    SEL_CMPL   = 2'd0,
    SEL_CMPH   = 2'd1,
    SEL_CTRL   = 2'd2,
    SEL_PERIOD = 2'd3
  } ch_reg_e;

endpackage

// File: rtl/tim_cmp_channel.sv
// tim_cmp_channel: one compare channel.
// Holds the 64-bit compare value, period increment, CTRL bits and the
// match edge detector. Produces a one-cycle fire pulse and the read data
// for its four registers.
// Ports:
//   sys_clk, sys_rst_n      clock, async active-low reset
//   cnt_val                 free-running 64-bit counter
//   wr_cmpl/cmph/ctrl/period  decoded write strobes for this channel
//   wdata, strb             write data and byte strobes
//   rd_sel                  register select for rd_data
//   fire                    match rising edge (combinational)
//   int_en                  CTRL.int_en
//   rd_data                 register read data
module tim_cmp_channel
  import tim_cmp_pkg::*;
#(
  parameter int PERIOD_W = 32
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] cnt_val,
  input  logic        wr_cmpl,
  input  logic        wr_cmph,
  input  logic        wr_ctrl,
  input  logic        wr_period,
  input  logic [31:0] wdata,
  input  logic [3:0]  strb,
  input  logic [1:0]  rd_sel,
  output logic        fire,
  output logic        int_en,
  output logic [31:0] rd_data
);

  localparam int PW_WR = (PERIOD_W < 32) ? PERIOD_W : 32;

  logic [63:0]         cmp, cmp_nxt;
  logic [PERIOD_W-1:0] period, period_nxt;
  logic                en, en_nxt;
  logic                periodic, periodic_nxt;
  logic                int_en_q, int_en_nxt;
  logic                match, match_prev;
  logic [31:0]         period_rd;

  // match already contains en, so match_prev naturally drops while disabled
  // and a 0->1 en write on a matching value fires on the next edge.
  assign match = en && (cnt_val == cmp);
  assign fire  = match && !match_prev;

  always_comb begin
    cmp_nxt      = cmp;
    en_nxt       = en;
    periodic_nxt = periodic;
    int_en_nxt   = int_en_q;
    period_nxt   = period;

    // Hardware update first; software writes below override written bytes.
    if (fire) begin
      if (periodic) cmp_nxt = cmp + 64'(period);
      else          en_nxt  = 1'b0;
    end

    for (int b = 0; b < 4; b++) begin
      if (wr_cmpl && strb[b]) cmp_nxt[8*b +: 8]      = wdata[8*b +: 8];
      if (wr_cmph && strb[b]) cmp_nxt[32 + 8*b +: 8] = wdata[8*b +: 8];
    end

    if (wr_ctrl && strb[0]) begin
      en_nxt       = wdata[CTRL_EN];
      periodic_nxt = wdata[CTRL_PERIODIC];
      int_en_nxt   = wdata[CTRL_INT_EN];
    end

    for (int k = 0; k < PW_WR; k++) begin
      if (wr_period && strb[k/8]) period_nxt[k] = wdata[k];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmp        <= '1;
      period     <= '0;
      en         <= 1'b0;
      periodic   <= 1'b0;
      int_en_q   <= 1'b0;
      match_prev <= 1'b0;
    end else begin
      cmp        <= cmp_nxt;
      period     <= period_nxt;
      en         <= en_nxt;
      periodic   <= periodic_nxt;
      int_en_q   <= int_en_nxt;
      match_prev <= match;
    end
  end

  generate
    if (PERIOD_W >= 32) begin : g_per_wide
      assign period_rd = period[31:0];
    end else begin : g_per_narrow
      assign period_rd = 32'(period);
    end
  endgenerate

  assign int_en = int_en_q;

  always_comb begin
    rd_data = '0;
    case (ch_reg_e'(rd_sel))
      SEL_CMPL:   rd_data = cmp[31:0];
      SEL_CMPH:   rd_data = cmp[63:32];
      SEL_CTRL:   rd_data = {29'd0, int_en_q, periodic, en};
      SEL_PERIOD: rd_data = period_rd;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: rtl/tim_cmp_bank.sv
// tim_cmp_bank: multi-channel compare and interrupt bank.
// Decodes the APB-side register map, keeps the shared ISR/OVR registers,
// muxes read data and flags access errors; compare state lives in
// tim_cmp_channel instances.
// Ports:
//   sys_clk, sys_rst_n        clock, async active-low reset
//   wr_en, rd_en              APB access-phase strobes
//   tim_paddr/pwdata/pstrb    byte address, write data, byte strobes
//   tim_prdata                read data, combinational from address
//   cnt_val                   free-running 64-bit counter
//   ch_int, tim_int           per-channel and combined interrupts
//   reg_error_flag            access error, combinational
module tim_cmp_bank
  import tim_cmp_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [11:0]       tim_paddr,
  input  logic [31:0]       tim_pwdata,
  input  logic [3:0]        tim_pstrb,
  output logic [31:0]       tim_prdata,
  input  logic [63:0]       cnt_val,
  output logic [NUM_CH-1:0] ch_int,
  output logic              tim_int,
  output logic              reg_error_flag
);

  localparam logic [11:0] CH_END = CH_BASE + 12'(MAX_CH) * CH_STRIDE;

  logic [2:0]        ch_idx;
  logic [3:0]        reg_off;
  logic              ch_slot, ch_valid, reg_aligned;
  logic              isr_hit, ovr_hit, mapped;
  logic [NUM_CH-1:0] ch_sel, wr_cmpl, wr_cmph, wr_ctrl, wr_period;
  logic [NUM_CH-1:0] fire, int_en;
  logic [NUM_CH-1:0] isr, ovr, isr_w1c, ovr_w1c;
  logic [31:0]       ch_rd [NUM_CH];

  // CH_BASE is 128-byte aligned, so the slot index and offset come
  // straight from the low address bits.
  assign ch_idx      = tim_paddr[6:4];
  assign reg_off     = tim_paddr[3:0];
  assign ch_slot     = (tim_paddr >= CH_BASE) && (tim_paddr < CH_END);
  assign ch_valid    = ch_slot && ({29'd0, ch_idx} < 32'(NUM_CH));
  assign reg_aligned = (reg_off[1:0] == 2'b00);
  assign isr_hit     = (tim_paddr == ISR_ADDR);
  assign ovr_hit     = (tim_paddr == OVR_ADDR);
  assign mapped      = isr_hit || ovr_hit || (ch_valid && reg_aligned);

  assign reg_error_flag = ((wr_en || rd_en) && ch_slot && !ch_valid) ||
                          (wr_en && !mapped);

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_sel[i]    = ch_valid && reg_aligned && (ch_idx == 3'(i));
      assign wr_cmpl[i]   = wr_en && ch_sel[i] && (reg_off == CMPL_OFF);
      assign wr_cmph[i]   = wr_en && ch_sel[i] && (reg_off == CMPH_OFF);
      assign wr_ctrl[i]   = wr_en && ch_sel[i] && (reg_off == CTRL_OFF);
      assign wr_period[i] = wr_en && ch_sel[i] && (reg_off == PERIOD_OFF);

      tim_cmp_channel #(
        .PERIOD_W (PERIOD_W)
      ) u_ch (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cnt_val   (cnt_val),
        .wr_cmpl   (wr_cmpl[i]),
        .wr_cmph   (wr_cmph[i]),
        .wr_ctrl   (wr_ctrl[i]),
        .wr_period (wr_period[i]),
        .wdata     (tim_pwdata),
        .strb      (tim_pstrb),
        .rd_sel    (reg_off[3:2]),
        .fire      (fire[i]),
        .int_en    (int_en[i]),
        .rd_data   (ch_rd[i])
      );
    end
  endgenerate

  assign isr_w1c = (wr_en && isr_hit && tim_pstrb[0]) ? tim_pwdata[NUM_CH-1:0] : '0;
  assign ovr_w1c = (wr_en && ovr_hit && tim_pstrb[0]) ? tim_pwdata[NUM_CH-1:0] : '0;

  // A hardware set on the same edge as a W1C wins; overrun uses the
  // pre-update status so a fire into an already-pending bit is caught.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      isr <= '0;
      ovr <= '0;
    end else begin
      isr <= (isr & ~isr_w1c) | fire;
      ovr <= (ovr & ~ovr_w1c) | (fire & isr);
    end
  end

  assign ch_int  = isr & int_en;
  assign tim_int = |ch_int;

  always_comb begin
    tim_prdata = '0;
    if (isr_hit) begin
      tim_prdata = 32'(isr);
    end else if (ovr_hit) begin
      tim_prdata = 32'(ovr);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel[c]) tim_prdata = ch_rd[c];
      end
    end
  end

endmodule

// File: tb/tb_tim_cmp_bank.sv
module tb_tim_cmp_bank;

  localparam int NCH = 4;
  localparam int PW  = 32;

  logic           sys_clk;
  logic           sys_rst_n;
  logic           wr_en, rd_en;
  logic [11:0]    tim_paddr;
  logic [31:0]    tim_pwdata;
  logic [3:0]     tim_pstrb;
  logic [31:0]    tim_prdata;
  logic [63:0]    cnt_val;
  logic [NCH-1:0] ch_int;
  logic           tim_int;
  logic           reg_error_flag;

  tim_cmp_bank #(.NUM_CH(NCH), .PERIOD_W(PW)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .tim_paddr      (tim_paddr),
    .tim_pwdata     (tim_pwdata),
    .tim_pstrb      (tim_pstrb),
    .tim_prdata     (tim_prdata),
    .cnt_val        (cnt_val),
    .ch_int         (ch_int),
    .tim_int        (tim_int),
    .reg_error_flag (reg_error_flag)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference model: register contents as the programmer sees them.
  logic [63:0]    m_cmp [NCH];
  logic [31:0]    m_per [NCH];
  logic [NCH-1:0] m_en, m_pd, m_ie, m_prev, m_isr, m_ovr;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cmp[i] = '1;
      m_per[i] = '0;
    end
    m_en = '0; m_pd = '0; m_ie = '0; m_prev = '0; m_isr = '0; m_ovr = '0;
  endtask

  // Channel index of a mapped, aligned channel register, else -1.
  function automatic int m_chan(input logic [11:0] a);
    int ai, idx;
    ai = a;
    if (ai < 256 || ai >= 384 || (ai % 4) != 0) return -1;
    idx = (ai - 256) / 16;
    return (idx < NCH) ? idx : -1;
  endfunction

  function automatic logic [31:0] m_rd(input logic [11:0] a);
    int c;
    c = m_chan(a);
    if (a == 12'h080) return 32'(m_isr);
    if (a == 12'h084) return 32'(m_ovr);
    if (c < 0) return 32'd0;
    case (int'(a) % 16)
      0:       return m_cmp[c][31:0];
      4:       return m_cmp[c][63:32];
      8:       return {29'd0, m_ie[c], m_pd[c], m_en[c]};
      default: return m_per[c];
    endcase
  endfunction

  function automatic logic m_err(input logic w, input logic r, input logic [11:0] a);
    int ai;
    ai = a;
    if ((w || r) && ai >= 256 && ai < 384 && (ai - 256) / 16 >= NCH) return 1'b1;
    if (w && !(ai == 128 || ai == 132 || m_chan(a) >= 0)) return 1'b1;
    return 1'b0;
  endfunction

  // One clock edge of the model, using the inputs currently applied.
  task automatic model_step();
    logic [NCH-1:0] hit, fire, old;
    int c;
    for (int i = 0; i < NCH; i++) begin
      hit[i]  = m_en[i] && (cnt_val == m_cmp[i]);
      fire[i] = hit[i] && !m_prev[i];
    end
    m_prev = hit;
    old = m_isr;
    if (wr_en && tim_paddr == 12'h080 && tim_pstrb[0]) m_isr = m_isr & ~tim_pwdata[NCH-1:0];
    if (wr_en && tim_paddr == 12'h084 && tim_pstrb[0]) m_ovr = m_ovr & ~tim_pwdata[NCH-1:0];
    m_isr = m_isr | fire;
    m_ovr = m_ovr | (fire & old);
    for (int i = 0; i < NCH; i++) begin
      if (fire[i]) begin
        if (m_pd[i]) m_cmp[i] = m_cmp[i] + 64'(m_per[i]);
        else         m_en[i]  = 1'b0;
      end
    end
    c = m_chan(tim_paddr);
    if (wr_en && c >= 0) begin
      case (int'(tim_paddr) % 16)
        0: for (int b = 0; b < 4; b++) if (tim_pstrb[b]) m_cmp[c][8*b +: 8] = tim_pwdata[8*b +: 8];
        4: for (int b = 0; b < 4; b++) if (tim_pstrb[b]) m_cmp[c][32 + 8*b +: 8] = tim_pwdata[8*b +: 8];
        8: if (tim_pstrb[0]) begin
             m_en[c] = tim_pwdata[0];
             m_pd[c] = tim_pwdata[1];
             m_ie[c] = tim_pwdata[2];
           end
        default: for (int b = 0; b < 4; b++) if (tim_pstrb[b]) m_per[c][8*b +: 8] = tim_pwdata[8*b +: 8];
      endcase
    end
  endtask

  // Apply one bus cycle, check combinational outputs, clock it, check state.
  task automatic cyc(input logic w, input logic r, input logic [11:0] a,
                     input logic [31:0] d, input logic [3:0] s, input int step);
    wr_en = w; rd_en = r; tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
    #1;
    check_val("prdata_pre", tim_prdata, m_rd(a));
    check_val("err", reg_error_flag, m_err(w, r, a));
    @(posedge sys_clk);
    model_step();
    #1;
    check_val("ch_int", ch_int, m_isr & m_ie);
    check_val("tim_int", tim_int, |(m_isr & m_ie));
    check_val("prdata_post", tim_prdata, m_rd(a));
    cnt_val = cnt_val + 64'(step);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d, 4'hF, 0);
  endtask

  task automatic rd(input logic [11:0] a, input int step);
    cyc(1'b0, 1'b1, a, 32'd0, 4'h0, step);
  endtask

  task automatic rd_expect(input logic [11:0] a, input logic [31:0] exp, input string tag);
    wr_en = 1'b0; rd_en = 1'b1; tim_paddr = a;
    #1;
    check_val(tag, tim_prdata, exp);
    cyc(1'b0, 1'b1, a, 32'd0, 4'h0, 0);
  endtask

  task automatic err_expect(input logic w, input logic r, input logic [11:0] a,
                            input logic [31:0] d, input logic exp, input string tag);
    wr_en = w; rd_en = r; tim_paddr = a; tim_pwdata = d; tim_pstrb = 4'hF;
    #1;
    check_val(tag, reg_error_flag, exp);
    cyc(w, r, a, d, 4'hF, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int sel, c, step;

    sys_rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; tim_paddr = '0; tim_pwdata = '0; tim_pstrb = '0;
    cnt_val = '0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check_val("rst_tim_int", tim_int, 1'b0);
    check_val("rst_prdata_0", tim_prdata, 32'd0);
    sys_rst_n = 1'b1;

    // Reset values
    rd_expect(12'h100, 32'hFFFF_FFFF, "rst_cmpl");
    rd_expect(12'h104, 32'hFFFF_FFFF, "rst_cmph");
    rd_expect(12'h108, 32'd0, "rst_ctrl");
    rd_expect(12'h080, 32'd0, "rst_isr");
    rd_expect(12'h084, 32'd0, "rst_ovr");

    // One-shot ch0 at 100
    cnt_val = 64'd90;
    wr(12'h100, 32'd100);
    wr(12'h104, 32'd0);
    wr(12'h108, 32'h5);
    repeat (15) rd(12'h080, 1);
    rd_expect(12'h080, 32'h1, "oneshot_isr");
    rd_expect(12'h108, 32'h4, "oneshot_en_clr");
    check_val("oneshot_tim_int", tim_int, 1'b1);
    wr(12'h080, 32'h1);
    check_val("w1c_tim_int", tim_int, 1'b0);

    // Periodic ch1: 10, 15, 20 with ISR left pending
    cnt_val = 64'd0;
    wr(12'h110, 32'd10);
    wr(12'h114, 32'd0);
    wr(12'h11C, 32'd5);
    wr(12'h118, 32'h7);
    repeat (23) rd(12'h080, 1);
    rd_expect(12'h084, 32'h2, "periodic_ovr");
    rd_expect(12'h110, 32'd25, "periodic_cmp");

    // Periodic wrap across 2^64
    wr(12'h118, 32'h0);
    wr(12'h110, 32'hFFFF_FFFE);
    wr(12'h114, 32'hFFFF_FFFF);
    wr(12'h11C, 32'd4);
    cnt_val = 64'hFFFF_FFFF_FFFF_FFFC;
    wr(12'h118, 32'h3);
    repeat (4) rd(12'h110, 1);
    rd_expect(12'h110, 32'd2, "wrap_cmpl");
    rd_expect(12'h114, 32'd0, "wrap_cmph");
    wr(12'h118, 32'h0);
    wr(12'h080, 32'hF);
    wr(12'h084, 32'hF);

    // Stalled counter on ch2: single fire
    wr(12'h120, 32'd50);
    wr(12'h124, 32'd0);
    cnt_val = 64'd50;
    wr(12'h128, 32'h5);
    repeat (8) rd(12'h080, 0);
    rd_expect(12'h084, 32'd0, "stall_ovr");
    rd_expect(12'h080, 32'h4, "stall_isr");

    // Same-edge W1C and fire on ch2
    wr(12'h120, 32'd60);
    cnt_val = 64'd59;
    wr(12'h128, 32'h1);
    cnt_val = 64'd60;
    wr(12'h080, 32'h4);
    rd_expect(12'h080, 32'h4, "w1c_vs_set");

    // Same-edge CMPL byte write and auto-advance on ch3
    wr(12'h080, 32'hF);
    wr(12'h084, 32'hF);
    cnt_val = 64'h16F;
    wr(12'h130, 32'h170);
    wr(12'h134, 32'd0);
    wr(12'h13C, 32'h100);
    wr(12'h138, 32'h3);
    cnt_val = 64'h170;
    cyc(1'b1, 1'b0, 12'h130, 32'hAB, 4'h1, 0);
    rd_expect(12'h130, 32'h2AB, "cmpl_vs_adv");
    wr(12'h138, 32'h0);

    // Access errors
    err_expect(1'b1, 1'b0, 12'h140, 32'h1234_5678, 1'b1, "err_wr_ch4");
    err_expect(1'b0, 1'b1, 12'h140, 32'h0, 1'b1, "err_rd_ch4");
    err_expect(1'b1, 1'b0, 12'h08C, 32'hFFFF_FFFF, 1'b1, "err_wr_08c");
    err_expect(1'b0, 1'b1, 12'h08C, 32'h0, 1'b0, "rd_08c_ok");
    err_expect(1'b1, 1'b0, 12'h102, 32'h0, 1'b1, "err_wr_misalign");
    err_expect(1'b1, 1'b0, 12'h100, 32'd7, 1'b0, "wr_ok");
    rd_expect(12'h140, 32'd0, "rd_ch4_zero");

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      sel  = $urandom_range(0, 9);
      c    = $urandom_range(0, NCH - 1);
      step = ($urandom_range(0, 3) == 0) ? 0 : 1;
      if ($urandom_range(0, 63) == 0 || cnt_val > 64'd320) cnt_val = 64'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      case (sel)
        0, 1, 2, 3: begin
          if ($urandom_range(0, 4) == 0) a = ($urandom_range(0, 1) == 0) ? 12'h080 : 12'h084;
          else a = 12'h100 + 12'(16 * c) + 12'(4 * $urandom_range(0, 3));
          cyc(1'b0, 1'b1, a, 32'd0, 4'h0, step);
        end
        4: cyc(1'b1, 1'b0, 12'h100 + 12'(16 * c), 32'($urandom_range(0, 300)), s, step);
        5: begin
          d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
          cyc(1'b1, 1'b0, 12'h104 + 12'(16 * c), d, s, step);
        end
        6: cyc(1'b1, 1'b0, 12'h108 + 12'(16 * c), 32'($urandom_range(0, 7)), s, step);
        7: cyc(1'b1, 1'b0, 12'h10C + 12'(16 * c), 32'($urandom_range(0, 12)), s, step);
        8: begin
          a = ($urandom_range(0, 1) == 0) ? 12'h080 : 12'h084;
          cyc(1'b1, 1'b0, a, $urandom, 4'hF, step);
        end
        default: begin
          case ($urandom_range(0, 5))
            0: a = 12'h140;
            1: a = 12'h170;
            2: a = 12'h08C;
            3: a = 12'h000;
            4: a = 12'h106;
            default: a = 12'h200;
          endcase
          if ($urandom_range(0, 1) == 0) cyc(1'b1, 1'b0, a, $urandom, 4'hF, step);
          else cyc(1'b0, 1'b1, a, 32'd0, 4'h0, step);
        end
      endcase
    end

    // Reset in the middle of a periodic run
    cnt_val = 64'd0;
    wr(12'h110, 32'd5);
    wr(12'h114, 32'd0);
    wr(12'h11C, 32'd3);
    wr(12'h118, 32'h7);
    repeat (12) rd(12'h080, 1);
    sys_rst_n = 1'b0;
    model_reset();
    tim_paddr = 12'h110;
    #1;
    check_val("rst_mid_tim_int", tim_int, 1'b0);
    check_val("rst_mid_ch_int", ch_int, '0);
    check_val("rst_mid_cmpl", tim_prdata, 32'hFFFF_FFFF);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    rd_expect(12'h110, 32'hFFFF_FFFF, "rst_mid_cmpl_after");
    rd_expect(12'h118, 32'd0, "rst_mid_ctrl");
    rd_expect(12'h11C, 32'd0, "rst_mid_period");
    rd_expect(12'h080, 32'd0, "rst_mid_isr");
    rd_expect(12'h084, 32'd0, "rst_mid_ovr");
    repeat (6) rd(12'h080, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tim_cmp_bank.md
# tim_cmp_bank

Multi-channel compare and interrupt bank for the timer subsystem. It generalises the single 64-bit compare/interrupt pair to NUM_CH independent compare channels. Each channel supports one-shot or periodic (auto-advancing) mode, per-channel interrupt enable, and overrun detection. It sits beside the timer register set on the same APB-decoded bus and consumes the free-running 64-bit counter value.

## Interface
- NUM_CH, 4, number of compare channels (1..8)
- PERIOD_W, 32, width of per-channel period increment (1..64)
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  APB write strobe (access phase, one cycle per transfer)
- rd_en  in  1  APB read strobe
- tim_paddr  in  12  byte address
- tim_pwdata  in  32  write data
- tim_pstrb  in  4  byte strobes
- tim_prdata  out  32  read data, combinational from address
- cnt_val  in  64  current counter value
- ch_int  out  NUM_CH  per-channel interrupt = status[i] & int_en[i]
- tim_int  out  1  OR of ch_int
- reg_error_flag  out  1  access error to apb_slave, combinational

## Operation
- Global registers:
  - 0x080 ISR: bits [NUM_CH-1:0] match status; W1C.
  - 0x084 OVR: bits [NUM_CH-1:0] overrun; W1C.
- Channel i registers, base 0x100 + 0x10·i:
  - +0x0 CMPL: compare[31:0], byte-strobed.
  - +0x4 CMPH: compare[63:32], byte-strobed.
  - +0x8 CTRL: bit0 en, bit1 periodic, bit2 int_en; strobe[0] only.
  - +0xC PERIOD: [PERIOD_W-1:0], byte-strobed; upper bits read 0.
- Reset values: compare = all ones; PERIOD = 0; CTRL = 0; ISR = 0; OVR = 0; internal match_prev = 0; ch_int = 0; tim_int = 0; tim_prdata = 0 for address 0.
- Match: match_i = en_i & (cnt_val == compare_i). Fire_i = match_i & !match_prev_i, registered each cycle. match_prev_i is forced to 0 while en_i = 0. A stalled counter that holds the matching value fires once only.
- On fire:
  - ISR[i] is set.
  - If ISR[i] was already 1, OVR[i] is also set.
  - One-shot (periodic = 0): hardware clears CTRL.en.
  - Periodic: compare_i <= compare_i + zero-extended PERIOD, modulo 2^64 (wrap silently).
- PERIOD = 0 in periodic mode: compare does not change. Fires once and stays latched until en is toggled.
- Errors (reg_error_flag = 1, write discarded):
  - Write or read to a channel slot with i >= NUM_CH.
  - Write to any unmapped offset.
- Reads of unmapped addresses return 0.
- Reads have no side effects.

## Timing
- Fire is evaluated on the edge where cnt_val == compare. ISR/OVR/compare/en update on that same edge. ch_int and tim_int rise in the cycle after the counter reaches the compare value (1-cycle latency).
- Simultaneous events on the same edge:
  - Hardware set and W1C of the same bit: set wins.
  - Software write to CMPL/CMPH/CTRL and hardware auto-advance or en-clear: software write wins for the written bytes/bits. Hardware updates the unwritten bytes.
- A write of CTRL.en 0->1 while cnt_val already equals compare fires on the next edge (match_prev is 0).
- Reset asserted mid-operation returns all state to reset values asynchronously. Outputs are low during reset.

## Structure
- Package tim_cmp_pkg holds:
  - ISR/OVR/channel base offsets, channel stride, and CMPL/CMPH/CTRL/PERIOD offsets.
  - CTRL bit indices.
  - MAX_CH = 8.
- Sub-module tim_cmp_channel, generated NUM_CH times. It holds compare, period, ctrl, match_prev, and the fire/advance logic. It outputs fire and the read data for its registers.
- Top-level logic holds address decode, ISR/OVR, the read mux and the error flag.

## Test plan
- Reset, then read 0x100/0x104 -> 0xFFFFFFFF; read CTRL/ISR/OVR -> 0; tim_int = 0.
- One-shot ch0: compare = 100, CTRL = 0x5, ramp cnt_val -> ISR = 0x1 and tim_int high the cycle after cnt = 100; CTRL.en reads 0; W1C 0x1 to ISR -> tim_int low.
- Periodic ch1: compare = 10, PERIOD = 5, CTRL = 0x7 -> fires at 10, 15, 20. Not clearing ISR before 15 sets OVR bit1. Compare = 0xFFFF_FFFF_FFFF_FFFE with PERIOD = 4 wraps to 2.
- Counter stalled at the compare value for 8 cycles (one-shot, en re-written each cycle is excluded) -> exactly one fire, OVR stays 0.
- Same-edge W1C of ISR[2] and fire on ch2 -> ISR[2] = 1. Same-edge CMPL write and auto-advance -> the written low word wins.
- With NUM_CH = 2, write to 0x120 -> reg_error_flag = 1, no state change. Write to 0x08C -> error. Assert sys_rst_n mid-periodic run -> all registers return to reset values.
